// File: rtl/symbol_deserializer_pkg.sv
// Shared types and constants for the receive-side symbol deserializer.
// Contents: FSM state enum, counter width helper, default start-of-frame symbol.
package deser_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2
  } state_e;

  localparam logic [7:0] START_SYM_DEFAULT = 8'hA5;

  // Width of a counter that must hold values 0..n (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/symbol_deserializer_if.sv
// Symbol-in / word-out bus of the deserializer.
// master: link + packet-layer side (drives sym_in, sym_valid, word_ready).
// slave : the deserializer (drives sym_ready, word_out, word_valid, frame_err, busy).
interface symbol_deserializer_if #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned SYM_WIDTH  = 8
);

  logic [SYM_WIDTH-1:0]  sym_in;
  logic                  sym_valid;
  logic                  sym_ready;
  logic [WORD_WIDTH-1:0] word_out;
  logic                  word_valid;
  logic                  word_ready;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output sym_in, sym_valid, word_ready,
    input  sym_ready, word_out, word_valid, frame_err, busy
  );

  modport slave (
    input  sym_in, sym_valid, word_ready,
    output sym_ready, word_out, word_valid, frame_err, busy
  );

endinterface

// File: rtl/symbol_deserializer_counter.sv
// Generic up-counter with synchronous clear (priority) and increment enable.
// Ports: clk, rst_n (async active-low), clr_i, inc_i, cnt_o (registered count).
module counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/symbol_deserializer_sipo.sv
// SIPO accumulator: shifts INWIDTH-bit symbols in at the LSB side so the
// first symbol of a word ends up in the top bits.
// Ports: clk, rst_n (async active-low), clr_i (sync clear), shift_i, d_i,
//        acc_c (accumulator value as it will be after this edge's shift).
module sipo_shift_register #(
  parameter int unsigned INWIDTH  = 8,
  parameter int unsigned OUTWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                shift_i,
  input  logic [INWIDTH-1:0]  d_i,
  output logic [OUTWIDTH-1:0] acc_c
);

  logic [OUTWIDTH-1:0] acc_q, acc_d, shifted_c;

  assign shifted_c = {acc_q[OUTWIDTH-INWIDTH-1:0], d_i};

  // Lets the caller capture a completed word on the same edge as its last symbol.
  assign acc_c = shift_i ? shifted_c : acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)        acc_d = '0;
    else if (shift_i) acc_d = shifted_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/symbol_deserializer.sv
// Receive-side SIPO stage: hunts for START_SYM, assembles the next
// WORD_WIDTH/SYM_WIDTH symbols MSB-first into a word, delivers it on a
// valid/ready handshake and flags stalled frames via an inactivity timeout.
// Ports: clk, rst_n (async active-low), bus (symbol_deserializer_if.slave:
//        sym_in/sym_valid/sym_ready, word_out/word_valid/word_ready,
//        frame_err pulse, busy).
// Optional build macro SYMBOL_PARITY_EN: each frame carries a trailing
// check symbol (XOR of the data symbols); a mismatch aborts the frame.
module symbol_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned          WORD_WIDTH = 32,
  parameter int unsigned          SYM_WIDTH  = 8,
  parameter logic [SYM_WIDTH-1:0] START_SYM  = SYM_WIDTH'(START_SYM_DEFAULT),
  parameter int unsigned          TIMEOUT    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  symbol_deserializer_if.slave bus
);

  localparam int unsigned NSYM  = WORD_WIDTH / SYM_WIDTH;
  localparam int unsigned CNT_W = cnt_width(NSYM);
  localparam int unsigned TMR_W = cnt_width(TIMEOUT);

  state_e                state_q, state_d;
  logic                  sym_ready_q, sym_ready_d;
  logic                  word_valid_q, word_valid_d;
  logic                  busy_q, busy_d;
  logic                  frame_err_q, frame_err_d;
  logic [WORD_WIDTH-1:0] word_out_q, word_out_d;

  logic                  accept_c;
  logic                  timeout_c;
  logic                  sr_clr_c, sr_shift_c;
  logic [WORD_WIDTH-1:0] acc_c;
  logic [CNT_W-1:0]      cnt_q;
  logic [TMR_W-1:0]      tmr_q;

  assign accept_c  = bus.sym_valid & sym_ready_q;
  assign timeout_c = (TIMEOUT != 0) && (tmr_q == TMR_W'(TIMEOUT - 1));

  // Symbol counter: runs only inside a frame.
  counter #(.WIDTH(CNT_W)) u_sym_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != COLLECT),
    .inc_i (accept_c && (state_q == COLLECT)),
    .cnt_o (cnt_q)
  );

  // Inactivity timer: counts idle COLLECT cycles, restarts on every accepted symbol.
  counter #(.WIDTH(TMR_W)) u_idle_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q != COLLECT) || accept_c),
    .inc_i ((state_q == COLLECT) && !accept_c && (TIMEOUT != 0)),
    .cnt_o (tmr_q)
  );

  sipo_shift_register #(.INWIDTH(SYM_WIDTH), .OUTWIDTH(WORD_WIDTH)) u_sipo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (sr_clr_c),
    .shift_i (sr_shift_c),
    .d_i     (bus.sym_in),
    .acc_c   (acc_c)
  );

`ifdef SYMBOL_PARITY_EN
  logic [SYM_WIDTH-1:0] par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= '0;
    else        par_q <= par_d;
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    word_out_d  = word_out_q;
    sr_clr_c    = 1'b0;
    sr_shift_c  = 1'b0;
`ifdef SYMBOL_PARITY_EN
    par_d       = par_q;
`endif

    unique case (state_q)
      HUNT: begin
        if (accept_c && (bus.sym_in == START_SYM)) begin
          state_d  = COLLECT;
          sr_clr_c = 1'b1;
`ifdef SYMBOL_PARITY_EN
          par_d    = '0;
`endif
        end
      end

      COLLECT: begin
        if (accept_c) begin
`ifdef SYMBOL_PARITY_EN
          if (cnt_q == CNT_W'(NSYM)) begin
            // Check symbol: accumulator is not shifted, so acc_c holds the word.
            if (bus.sym_in == par_q) begin
              word_out_d = acc_c;
              state_d    = DELIVER;
            end else begin
              frame_err_d = 1'b1;
              state_d     = HUNT;
            end
          end else begin
            sr_shift_c = 1'b1;
            par_d      = par_q ^ bus.sym_in;
          end
`else
          sr_shift_c = 1'b1;
          if (cnt_q == CNT_W'(NSYM - 1)) begin
            word_out_d = acc_c;
            state_d    = DELIVER;
          end
`endif
        end else if (timeout_c) begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
        end
      end

      DELIVER: begin
        if (bus.word_ready) state_d = HUNT;
      end

      default: state_d = HUNT;
    endcase

    // Handshake/status outputs are registered copies of the next state.
    sym_ready_d  = (state_d != DELIVER);
    word_valid_d = (state_d == DELIVER);
    busy_d       = (state_d != HUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      sym_ready_q  <= 1'b1;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      word_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      sym_ready_q  <= sym_ready_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      word_out_q   <= word_out_d;
    end
  end

  assign bus.sym_ready  = sym_ready_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_out   = word_out_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_symbol_deserializer.sv
// Directed bench for symbol_deserializer (default parameters). Inputs change
// on the falling edge; outputs are checked on the following falling edge.
module tb_symbol_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  symbol_deserializer_if #(.WORD_WIDTH(32), .SYM_WIDTH(8)) bus ();

  symbol_deserializer #(
    .WORD_WIDTH (32),
    .SYM_WIDTH  (8),
    .START_SYM  (8'hA5),
    .TIMEOUT    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int wv_cycles = 0;

  always @(posedge clk) begin
    if (bus.frame_err === 1'b1)  err_pulses++;
    if (bus.word_valid === 1'b1) wv_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] s);
    bus.sym_in    = s;
    bus.sym_valid = 1'b1;
    @(negedge clk);
    bus.sym_valid = 1'b0;
    bus.sym_in    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] w);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    send(8'hA5);
    for (int i = 0; i < 4; i++) begin
      s = w[31-8*i -: 8];
      p = p ^ s;
`ifndef SYMBOL_PARITY_EN
      if (i == 3) check("wv_before_last", 32'(bus.word_valid), 32'd0);
`endif
      send(s);
    end
`ifdef SYMBOL_PARITY_EN
    check("wv_before_check", 32'(bus.word_valid), 32'd0);
    send(p);
`endif
  endtask

  task automatic expect_word(input string tag, input logic [31:0] w);
    check({tag, "_valid"}, 32'(bus.word_valid), 32'd1);
    check({tag, "_word"}, bus.word_out, w);
    check({tag, "_ready"}, 32'(bus.sym_ready), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.word_valid), 32'd0);
    check({tag, "_ready"}, 32'(bus.sym_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int wv0;
    int e0;
    bus.sym_in     = '0;
    bus.sym_valid  = 1'b0;
    bus.word_ready = 1'b1;

    // Reset values
    idle(2);
    check("rst_ready", 32'(bus.sym_ready), 32'd1);
    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_word", bus.word_out, 32'd0);
    check("rst_err", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Basic frame, single-cycle word_valid
    wv0 = wv_cycles;
    send_frame(32'h12345678);
    expect_word("basic", 32'h12345678);
    idle(1);
    expect_idle("basic_after");
    check("basic_wv_cycles", 32'(wv_cycles - wv0), 32'd1);

    // Noise before the start symbol
    e0 = err_pulses;
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    check("noise_busy", 32'(bus.busy), 32'd0);
    send_frame(32'hDEADBEEF);
    expect_word("noise", 32'hDEADBEEF);
    idle(1);
    check("noise_no_err", 32'(err_pulses - e0), 32'd0);

    // Backpressure: five cycles with word_ready low, symbols offered meanwhile
    bus.word_ready = 1'b0;
    send_frame(32'h11223344);
    expect_word("bp0", 32'h11223344);
    bus.sym_in    = 8'hA5;
    bus.sym_valid = 1'b1;
    for (int k = 1; k < 5; k++) begin
      idle(1);
      expect_word("bp_hold", 32'h11223344);
    end
    bus.sym_valid  = 1'b0;
    bus.word_ready = 1'b1;
    idle(1);
    expect_idle("bp_after");
    check("bp_word_kept", bus.word_out, 32'h11223344);

    // Start symbol inside the payload is data
    send_frame(32'hA5A5A5A5);
    expect_word("embed", 32'hA5A5A5A5);
    idle(1);

    // Timeout after 16 idle cycles
    e0 = err_pulses;
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    idle(15);
    check("to_err_early", 32'(bus.frame_err), 32'd0);
    check("to_busy_early", 32'(bus.busy), 32'd1);
    idle(1);
    check("to_err", 32'(bus.frame_err), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd0);
    check("to_word_kept", bus.word_out, 32'hA5A5A5A5);
    check("to_valid", 32'(bus.word_valid), 32'd0);
    idle(1);
    check("to_err_pulse", 32'(bus.frame_err), 32'd0);
    check("to_err_count", 32'(err_pulses - e0), 32'd1);
    send_frame(32'h01020304);
    expect_word("after_to", 32'h01020304);
    idle(1);

    // Acceptance on the would-be timeout edge keeps the frame alive
    e0 = err_pulses;
    send(8'hA5);
    idle(15);
    send(8'h11);
    check("race_err", 32'(bus.frame_err), 32'd0);
    check("race_busy", 32'(bus.busy), 32'd1);
    idle(15);
    send(8'h22);
    send(8'h33);
    idle(15);
    send(8'h44);
`ifdef SYMBOL_PARITY_EN
    send(8'h44);
`endif
    expect_word("race", 32'h11223344);
    idle(1);
    check("race_err_count", 32'(err_pulses - e0), 32'd0);

    // Reset in the middle of a frame
    e0 = err_pulses;
    send(8'hA5);
    send(8'h12);
    rst_n = 1'b0;
    #1;
    expect_idle("midrst");
    check("midrst_word", bus.word_out, 32'd0);
    check("midrst_err", 32'(bus.frame_err), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    check("midrst_err_count", 32'(err_pulses - e0), 32'd0);
    send_frame(32'h9ABCDEF0);
    expect_word("post_rst", 32'h9ABCDEF0);
    idle(1);

`ifdef SYMBOL_PARITY_EN
    // Bad check symbol aborts the frame
    wv0 = wv_cycles;
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    send(8'h56);
    send(8'h78);
    send(8'h09);
    check("par_err", 32'(bus.frame_err), 32'd1);
    expect_idle("par_bad");
    idle(1);
    check("par_err_pulse", 32'(bus.frame_err), 32'd0);
    check("par_no_word", 32'(wv_cycles - wv0), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
